// File: rtl/uart_rx.sv
// uart_rx: UART receiver with a two-flop input synchronizer, four selectable baud dividers and mid-bit sampling.
// Frames are 8N1; defining UART_RX_PARITY_EN switches to 8E1 and enables parity_err.
module uart_rx #(
  parameter logic [13:0] DIV9600  = 14'd10417,
  parameter logic [13:0] DIV19200 = 14'd5208,
  parameter logic [13:0] DIV38400 = 14'd2604,
  parameter logic [13:0] DIV57600 = 14'd1736
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] select,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif
  state_t      state_q, state_d;
  logic [1:0]  sync_q;
  logic        rxs;
  logic [13:0] timer_q, timer_d, div_q, div_d, sel_div;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d, data_q, data_d;
  logic        valid_q, valid_d, ferr_q, ferr_d;
  logic        tick;
`ifdef UART_RX_PARITY_EN
  logic        par_q, par_d, perr_q, perr_d;
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif
  assign rxs       = sync_q[1];
  assign tick      = timer_q == 14'd0;
  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign busy      = state_q != IDLE;
  assign sel_div   = select == 2'd0 ? DIV9600 :
                     select == 2'd1 ? DIV19200 :
                     select == 2'd2 ? DIV38400 : DIV57600;
  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx};
  // The timer holds at zero when idle so it can never wrap.
  always_comb begin
    state_d = state_q;
    timer_d = tick ? timer_q : timer_q - 14'd1;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: if (!rxs) begin
        div_d   = sel_div;
        timer_d = (sel_div >> 1) - 14'd1;
        bit_d   = 3'd0;
        state_d = START;
      end
      START: if (tick) begin
        timer_d = div_q - 14'd1;
        state_d = rxs ? IDLE : DATA;
      end
      DATA: if (tick) begin
        timer_d        = div_q - 14'd1;
        shift_d[bit_q] = rxs;
        bit_d          = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
        state_d        = bit_q == 3'd7 ? PARITY : DATA;
`else
        state_d        = bit_q == 3'd7 ? STOP : DATA;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        timer_d = div_q - 14'd1;
        par_d   = rxs;
        state_d = STOP;
      end
`endif
      STOP: if (tick) begin
        timer_d = div_q - 14'd1;
        state_d = rxs ? IDLE : WAIT_IDLE;
        ferr_d  = !rxs;
`ifdef UART_RX_PARITY_EN
        perr_d  = rxs && ^{shift_q, par_q};
        valid_d = rxs && !(^{shift_q, par_q});
`else
        valid_d = rxs;
`endif
        data_d  = valid_d ? shift_q : data_q;
      end
      WAIT_IDLE: state_d = rxs ? IDLE : WAIT_IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized bench for uart_rx with scaled-down baud dividers.
// Expected pulses, data and timing come from frame-level arithmetic on the transmitted bits.
module tb_uart_rx;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] select = 2'd0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, busy;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  typedef struct {int c; logic v; logic f; logic p; logic [7:0] d;} ev_t;
  ev_t  evq[$];
  ev_t  e;
  int   busy_fall = -1;
  int   busy_rise = -1;
  int   viol = 0;
  int   perr_seen = 0;
  logic prev_any = 1'b0;
  logic prev_busy = 1'b0;
  logic [7:0] exp_data = 8'h00;

  uart_rx #(.DIV9600(14'd521), .DIV19200(14'd260), .DIV38400(14'd130), .DIV57600(14'd87)) dut (
    .clk(clk), .rst(rst), .select(select), .rx(rx), .rx_data(rx_data),
    .rx_valid(rx_valid), .frame_err(frame_err), .parity_err(parity_err), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (!rst) begin
    if ($countones({rx_valid, frame_err, parity_err}) > 1 || ((rx_valid | frame_err | parity_err) && prev_any)) viol++;
    if (rx_valid | frame_err | parity_err) begin
      e.c = cyc; e.v = rx_valid; e.f = frame_err; e.p = parity_err; e.d = rx_data;
      evq.push_back(e);
    end
    if (parity_err) perr_seen++;
    if (prev_busy && !busy) busy_fall = cyc;
    if (!prev_busy && busy) busy_rise = cyc;
    prev_any  = rx_valid | frame_err | parity_err;
    prev_busy = busy;
  end

  function automatic int div_of(input logic [1:0] s);
    return s == 2'd0 ? 521 : s == 2'd1 ? 260 : s == 2'd2 ? 130 : 87;
  endfunction

  // {valid, frame_err, parity_err} expected for a frame
  function automatic logic [2:0] exp_kind(input logic [7:0] d, input logic par, input logic stop);
    if (!stop) return 3'b010;
    return (NB == 10 && ^{d, par}) ? 3'b001 : 3'b100;
  endfunction

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, output int t0);
    int dv;
    logic [8:0] bits;
    dv   = div_of(select);
    bits = {par, d};
    t0   = cyc;
    hold(1'b0, dv);
    select = 2'($urandom);
    for (int k = 0; k < NB - 1; k++) hold(bits[k], dv);
    hold(stop, dv);
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rx_data, rx_valid, frame_err, parity_err, busy} !== 12'h000) begin
      errors++; $display("FAIL reset_outputs got %h exp 000", {rx_data, rx_valid, frame_err, parity_err, busy});
    end
    rst = 1'b0;
    hold(1'b1, 5);
    checks++;
    if ({rx_data, rx_valid, frame_err, parity_err, busy} !== 12'h000) begin
      errors++; $display("FAIL idle_after_reset got %h exp 000", {rx_data, rx_valid, frame_err, parity_err, busy});
    end
  endtask

  task automatic test_basic;
    int t0;
    select = 2'd0;
    evq.delete();
    send_frame(8'hA5, 1'b0, 1'b1, t0);
    hold(1'b1, 10);
    checks++;
    if (evq.size() !== 1) begin
      errors++; $display("FAIL basic_count got %0d exp 1", evq.size());
    end else begin
      checks++;
      if ({evq[0].v, evq[0].f, evq[0].p} !== 3'b100) begin
        errors++; $display("FAIL basic_kind got %b exp 100", {evq[0].v, evq[0].f, evq[0].p});
      end
      checks++;
      if (evq[0].d !== 8'hA5) begin
        errors++; $display("FAIL basic_data got %h exp a5", evq[0].d);
      end
      checks++;
      if (evq[0].c !== t0 + 3 + 260 + NB * 521) begin
        errors++; $display("FAIL basic_latency got %0d exp %0d", evq[0].c - t0, 3 + 260 + NB * 521);
      end
    end
    exp_data = 8'hA5;
  endtask

  task automatic test_back_to_back;
    int t0;
    select = 2'd3;
    evq.delete();
    send_frame(8'h00, 1'b0, 1'b1, t0);
    select = 2'd3;
    send_frame(8'hFF, 1'b0, 1'b1, t0);
    hold(1'b1, 10);
    checks++;
    if (evq.size() !== 2) begin
      errors++; $display("FAIL b2b_count got %0d exp 2", evq.size());
    end else begin
      checks++;
      if ({evq[0].v, evq[0].f, evq[0].d, evq[1].v, evq[1].f, evq[1].d} !== {2'b10, 8'h00, 2'b10, 8'hFF}) begin
        errors++; $display("FAIL b2b_events got %b/%h %b/%h exp 10/00 10/ff",
                           {evq[0].v, evq[0].f}, evq[0].d, {evq[1].v, evq[1].f}, evq[1].d);
      end
    end
    exp_data = 8'hFF;
  endtask

  task automatic test_false_start;
    int t0;
    select = 2'd1;
    evq.delete();
    busy_fall = -1;
    busy_rise = -1;
    t0 = cyc;
    hold(1'b0, 100);
    hold(1'b1, 300);
    checks++;
    if (evq.size() !== 0) begin
      errors++; $display("FAIL false_start_pulses got %0d exp 0", evq.size());
    end
    checks++;
    if (busy_rise !== t0 + 3) begin
      errors++; $display("FAIL false_start_busy_rise got %0d exp %0d", busy_rise - t0, 3);
    end
    checks++;
    if (busy_fall !== t0 + 2 + 130 + 1) begin
      errors++; $display("FAIL false_start_busy_fall got %0d exp %0d", busy_fall - t0 - 2, 131);
    end
  endtask

  task automatic test_frame_err;
    int t0;
    int r;
    select = 2'd2;
    evq.delete();
    send_frame(8'h3C, 1'b0, 1'b0, t0);
    hold(1'b0, 250);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL ferr_busy_held got %b exp 1", busy);
    end
    busy_fall = -1;
    r = cyc;
    hold(1'b1, 20);
    checks++;
    if (busy_fall !== r + 3) begin
      errors++; $display("FAIL ferr_busy_fall got %0d exp %0d", busy_fall - r, 3);
    end
    checks++;
    if (evq.size() !== 1) begin
      errors++; $display("FAIL ferr_count got %0d exp 1", evq.size());
    end else begin
      checks++;
      if ({evq[0].v, evq[0].f, evq[0].p, evq[0].d} !== {3'b010, exp_data}) begin
        errors++; $display("FAIL ferr_event got %b/%h exp 010/%h", {evq[0].v, evq[0].f, evq[0].p}, evq[0].d, exp_data);
      end
      checks++;
      if (evq[0].c !== t0 + 3 + 65 + NB * 130) begin
        errors++; $display("FAIL ferr_latency got %0d exp %0d", evq[0].c - t0, 3 + 65 + NB * 130);
      end
    end
    checks++;
    if (rx_data !== exp_data) begin
      errors++; $display("FAIL ferr_rx_data got %h exp %h", rx_data, exp_data);
    end
  endtask

  task automatic test_reset_mid;
    int t0;
    logic [8:0] bits;
    bits = {1'b0, 8'h55};
    select = 2'd0;
    evq.delete();
    t0 = cyc;
    hold(1'b0, 521);
    for (int k = 0; k < 4; k++) hold(bits[k], 521);
    rx = bits[4];
    repeat (260) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL mid_busy_before_reset got %b exp 1", busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({rx_data, rx_valid, frame_err, parity_err, busy} !== 12'h000) begin
      errors++; $display("FAIL mid_async_reset got %h exp 000", {rx_data, rx_valid, frame_err, parity_err, busy});
    end
    @(posedge clk);
    #1;
    for (int k = 5; k < NB; k++) hold(bits[k], 521);
    hold(1'b1, 521);
    rst = 1'b0;
    exp_data = 8'h00;
    hold(1'b1, 10);
    checks++;
    if (evq.size() !== 0) begin
      errors++; $display("FAIL mid_aborted_pulses got %0d exp 0", evq.size());
    end
    select = 2'd0;
    send_frame(8'h12, 1'b0, 1'b1, t0);
    hold(1'b1, 10);
    checks++;
    if (evq.size() !== 1) begin
      errors++; $display("FAIL mid_next_count got %0d exp 1", evq.size());
    end else begin
      checks++;
      if ({evq[0].v, evq[0].d} !== {1'b1, 8'h12}) begin
        errors++; $display("FAIL mid_next_frame got %b/%h exp 1/12", evq[0].v, evq[0].d);
      end
    end
    exp_data = 8'h12;
  endtask

  task automatic test_random;
    int t0;
    int dv;
    logic [7:0] d;
    logic [1:0] s;
    logic stop, par;
    logic [2:0] kind;
    for (int i = 0; i < 10; i++) begin
      d    = 8'($urandom);
      s    = 2'($urandom);
      stop = $urandom_range(0, 3) != 0;
      par  = $urandom_range(0, 3) == 0 ? ~^d : ^d;
      kind = exp_kind(d, par, stop);
      dv   = div_of(s);
      select = s;
      evq.delete();
      send_frame(d, par, stop, t0);
      hold(1'b1, $urandom_range(1, 6));
      checks++;
      if (evq.size() !== 1) begin
        errors++; $display("FAIL rand%0d_count got %0d exp 1", i, evq.size());
      end else begin
        checks++;
        if ({evq[0].v, evq[0].f, evq[0].p} !== kind) begin
          errors++; $display("FAIL rand%0d_kind got %b exp %b", i, {evq[0].v, evq[0].f, evq[0].p}, kind);
        end
        checks++;
        if (evq[0].d !== (kind[2] ? d : exp_data)) begin
          errors++; $display("FAIL rand%0d_data got %h exp %h", i, evq[0].d, kind[2] ? d : exp_data);
        end
        checks++;
        if (evq[0].c !== t0 + 3 + dv / 2 + NB * dv) begin
          errors++; $display("FAIL rand%0d_latency got %0d exp %0d", i, evq[0].c - t0, 3 + dv / 2 + NB * dv);
        end
      end
      if (kind[2]) exp_data = d;
    end
  endtask

  task automatic test_parity;
`ifdef UART_RX_PARITY_EN
    int t0;
    select = 2'd3;
    evq.delete();
    send_frame(8'h07, 1'b0, 1'b1, t0);
    hold(1'b1, 5);
    select = 2'd3;
    send_frame(8'h07, 1'b1, 1'b1, t0);
    hold(1'b1, 5);
    checks++;
    if (evq.size() !== 2) begin
      errors++; $display("FAIL parity_count got %0d exp 2", evq.size());
    end else begin
      checks++;
      if ({evq[0].v, evq[0].f, evq[0].p, evq[0].d} !== {3'b001, exp_data}) begin
        errors++; $display("FAIL parity_bad got %b/%h exp 001/%h", {evq[0].v, evq[0].f, evq[0].p}, evq[0].d, exp_data);
      end
      checks++;
      if ({evq[1].v, evq[1].f, evq[1].p, evq[1].d} !== {3'b100, 8'h07}) begin
        errors++; $display("FAIL parity_good got %b/%h exp 100/07", {evq[1].v, evq[1].f, evq[1].p}, evq[1].d);
      end
    end
    exp_data = 8'h07;
`else
    checks++;
    if (perr_seen !== 0 || parity_err !== 1'b0) begin
      errors++; $display("FAIL parity_tied got %0d pulses exp 0", perr_seen);
    end
`endif
  endtask

  task automatic test_protocol;
    checks++;
    if (viol !== 0) begin
      errors++; $display("FAIL pulse_exclusive got %0d violations exp 0", viol);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_false_start;
    test_frame_err;
    test_reset_mid;
    test_random;
    test_parity;
    test_protocol;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have these ports:
- clk  input  1  100 MHz system clock.
- rst  input  1  reset; asynchronous, active-high.
- select  input  2  baud select: 00 = 9600, 01 = 19200, 10 = 38400, 11 = 57600.
- rx  input  1  serial line; idles high; asynchronous to clk.
- rx_data  output  8  last received byte.
- rx_valid  output  1  one-cycle pulse; rx_data is valid.
- frame_err  output  1  one-cycle pulse; stop bit sampled low.
- parity_err  output  1  one-cycle pulse; parity mismatch.
- busy  output  1  high from start-edge detection until return to IDLE.

REQ-002 The module SHALL have these parameters (name, default, meaning):
- DIV9600, 10417, clk cycles per bit at 9600 baud.
- DIV19200, 5208, clk cycles per bit at 19200 baud.
- DIV38400, 2604, clk cycles per bit at 38400 baud.
- DIV57600, 1736, clk cycles per bit at 57600 baud.

Function
REQ-003 rx SHALL pass through a two-flop synchronizer; all logic SHALL use the synchronized value (rxs).
REQ-004 The state machine SHALL have the states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE.
REQ-005 In IDLE, when rxs = 0, the FSM SHALL latch the divider selected by select into D, clear the bit counter, enter START and assert busy. That cycle is edge cycle E.
REQ-006 Changes on select after E SHALL have no effect until the next frame.
REQ-007 The single bit-timer SHALL be a down-counter of at least 14 bits.
- It SHALL reload on every sample.
- It SHALL NOT wrap or underflow.
REQ-008 Sample points SHALL be timed from E:
- Start bit at E + floor(D/2).
- Data bit k (k = 0..7, LSB first) at E + floor(D/2) + (k+1)*D.
- Stop bit at E + floor(D/2) + 9*D, or + 10*D when parity is compiled in.
REQ-009 False start: if the start-bit sample is 1, the FSM SHALL return to IDLE with no output pulse, and busy SHALL fall the next cycle.
REQ-010 Each DATA sample SHALL shift into a shift register at bit position k; the FSM SHALL leave DATA after the 8th sample.
REQ-011 When the stop sample is 1:
- rx_data SHALL update to the shift register on the next cycle.
- rx_valid SHALL pulse for exactly that cycle.
- The FSM SHALL go to IDLE.
REQ-012 When the stop sample is 0:
- frame_err SHALL pulse for one cycle.
- rx_data SHALL keep its previous value.
- rx_valid SHALL stay low.
- The FSM SHALL go to WAIT_IDLE, which exits to IDLE on the first cycle rxs = 1.
REQ-013 rx_valid, frame_err and parity_err SHALL never be high in the same cycle and SHALL never be high for two consecutive cycles.
REQ-014 rx_data SHALL hold its value until the next good frame. There is no overrun detection.
REQ-015 busy SHALL be low in IDLE and high in all other states.

Reset
REQ-016 While rst = 1, and asynchronously on its assertion:
- The FSM SHALL be in IDLE.
- rx_data SHALL be 0x00.
- rx_valid, frame_err, parity_err and busy SHALL be 0.
- The synchronizer flops SHALL be 1.
- Counters SHALL be 0.
REQ-017 Reset during a frame SHALL abort the frame with no output pulse. After release, the next falling edge SHALL start a new frame, including an edge that occurs mid-byte.

Configuration
REQ-018 With macro UART_RX_PARITY_EN defined:
- The FSM SHALL enter PARITY after DATA and sample one even-parity bit at E + floor(D/2) + 9*D.
- If XOR(data, parity bit) = 1, parity_err SHALL pulse in place of rx_valid, and rx_data SHALL be unchanged.
- frame_err SHALL take priority over parity_err.
REQ-019 Without UART_RX_PARITY_EN:
- The PARITY state and its logic SHALL be absent.
- parity_err SHALL be tied to 0.
- The frame SHALL be 8N1.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- select = 00, send 8N1 byte 0xA5 at 9600 baud -> one rx_valid pulse with rx_data = 0xA5, 1 + floor(10417/2) + 9*10417 cycles after E.
- select = 11, send 0x00 then 0xFF back-to-back -> two rx_valid pulses with values 0x00 then 0xFF, and no frame_err.
- select = 01, rx low for 2000 cycles then high -> no pulse, and busy falls 2605 cycles after E.
- select = 10, send 0x3C with stop bit forced low, line held low 5000 more cycles -> frame_err pulse, rx_data unchanged, busy high until rx returns high.
- Assert rst during data bit 4 of 0x55 at 9600 baud -> all outputs 0 at once, no pulse, and the next valid frame 0x12 is received correctly.
- UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> parity_err pulse; with parity bit 1 -> rx_valid with rx_data = 0x07.
